stage2_decode: RTL and testbench

- Receive-side counterpart of the stage-2 check-bit append.
- Takes the 17-bit stage-2 word {data[15:0], chk}, strips the check bit and recomputes it from the same key_bits[1:0] rule.
- Outputs the 16-bit payload with an ok/error verdict and a done flag.
- Sits after stage 2 and ahead of the stage-1 inverse in the decrypt path.

---
 rtl/stage2_decode.sv | 119 +++++++++++
 tb/tb_stage2_decode.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/stage2_decode.sv
// Stage-2 receive decode: strips the check bit, recomputes it from key[1:0]; STAGE2_DEC_ERRCNT_EN adds err_cnt.
// Latency: stg2_done sampled at edge N gives done=1 after edge N+1.
// Backpressure: result held in DONE until ack; REARM waits for stg2_done low before the next capture.
module stage2_decode #(
    parameter int ERR_W = 8
) (
    input  logic             clk2,
    input  logic             rst_n,
    input  logic [4:0]       key_bits,
    input  logic [16:0]      stg2_in,
    input  logic             stg2_done,
    input  logic             ack,
    output logic [15:0]      dec_out,
    output logic             chk_ok,
    output logic             chk_err,
    output logic             done,
    output logic             busy
`ifdef STAGE2_DEC_ERRCNT_EN
    ,
    output logic [ERR_W-1:0] err_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, CHECK, DONE, REARM} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [16:0] r_word;
    logic [1:0]  r_key;
    logic [15:0] r_dec;
    logic        r_ok;
    logic        r_err;
    logic        r_done;
    logic        w_expected;
    logic        w_match;
    logic        w_unused_key;

    assign w_unused_key = &{1'b0, key_bits[4:2]};

    always_ff @(posedge clk2 or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:  if (stg2_done)  w_next = CHECK;
            CHECK:                 w_next = DONE;
            DONE:  if (ack)        w_next = REARM;
            REARM: if (!stg2_done) w_next = IDLE;
            default:               w_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state != IDLE);
    end

    // Word and key are frozen at capture so later input changes cannot affect the result in flight.
    always_ff @(posedge clk2 or negedge rst_n) begin
        if (!rst_n) begin
            r_word <= '0;
            r_key  <= '0;
        end else if (r_state == IDLE && stg2_done) begin
            r_word <= stg2_in;
            r_key  <= key_bits[1:0];
        end
    end

    always_comb begin
        w_expected = 1'b0;
        unique case (r_key)
            2'b00:   w_expected = ~^r_word[16:1];
            2'b10:   w_expected = &r_word[16:1];
            default: w_expected = |r_word[16:1];
        endcase
    end

    assign w_match = (r_word[0] == w_expected);

    always_ff @(posedge clk2 or negedge rst_n) begin
        if (!rst_n) begin
            r_dec  <= '0;
            r_ok   <= 1'b0;
            r_err  <= 1'b0;
            r_done <= 1'b0;
        end else if (r_state == CHECK) begin
            r_dec  <= r_word[16:1];
            r_ok   <= w_match;
            r_err  <= ~w_match;
            r_done <= 1'b1;
        end else if (r_state == DONE && ack) begin
            // dec_out intentionally keeps the last payload
            r_ok   <= 1'b0;
            r_err  <= 1'b0;
            r_done <= 1'b0;
        end
    end

`ifdef STAGE2_DEC_ERRCNT_EN
    logic [ERR_W-1:0] r_err_cnt;

    always_ff @(posedge clk2 or negedge rst_n) begin
        if (!rst_n)
            r_err_cnt <= '0;
        else if (r_state == CHECK && !w_match && r_err_cnt != {ERR_W{1'b1}})
            r_err_cnt <= r_err_cnt + 1'b1;
    end

    assign err_cnt = r_err_cnt;
`endif

    assign dec_out = r_dec;
    assign chk_ok  = r_ok;
    assign chk_err = r_err;
    assign done    = r_done;

endmodule

// File: tb/tb_stage2_decode.sv
// Randomized scoreboard bench for stage2_decode against a popcount-based reference model.
module tb_stage2_decode;

    localparam int TB_ERR_W = 2;
    localparam int CNT_MAX  = (1 << TB_ERR_W) - 1;

    logic        clk2 = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  key_bits = '0;
    logic [16:0] stg2_in = '0;
    logic        stg2_done = 1'b0;
    logic        ack = 1'b0;
    logic [15:0] dec_out;
    logic        chk_ok;
    logic        chk_err;
    logic        done;
    logic        busy;
`ifdef STAGE2_DEC_ERRCNT_EN
    logic [TB_ERR_W-1:0] err_cnt;
`endif

    stage2_decode #(.ERR_W(TB_ERR_W)) dut (
        .clk2      (clk2),
        .rst_n     (rst_n),
        .key_bits  (key_bits),
        .stg2_in   (stg2_in),
        .stg2_done (stg2_done),
        .ack       (ack),
        .dec_out   (dec_out),
        .chk_ok    (chk_ok),
        .chk_err   (chk_err),
        .done      (done),
        .busy      (busy)
`ifdef STAGE2_DEC_ERRCNT_EN
        ,
        .err_cnt   (err_cnt)
`endif
    );

    always #5 clk2 = ~clk2;

    typedef struct {
        logic [15:0] dec;
        logic        ok;
        int          cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   exp_cnt = 0;
    logic prev_done = 1'b0;

    // Reference rule expressed through the population count of the payload.
    function automatic logic model_chk(input logic [15:0] d, input logic [1:0] k);
        int ones = 0;
        for (int i = 0; i < 16; i++) ones += int'(d[i]);
        case (k)
            2'd0:    return (ones % 2) == 0;
            2'd2:    return ones == 16;
            default: return ones > 0;
        endcase
    endfunction

    task automatic check_val(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: pops one expectation on each rising done and checks the verdict invariants every cycle.
    always @(negedge clk2) begin
        if (done && !prev_done) begin
            if (exp_q.size() == 0) begin
                check_val("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check_val("dec_out", dec_out, e.dec);
                check_val("chk_ok", chk_ok, e.ok);
                check_val("chk_err", chk_err, !e.ok);
`ifdef STAGE2_DEC_ERRCNT_EN
                check_val("err_cnt", err_cnt, e.cnt);
`endif
            end
        end
        if ((chk_ok && chk_err) || (!done && (chk_ok || chk_err)))
            check_val("verdict_invariant", {chk_ok, chk_err, done}, 0);
        prev_done = done;
    end

    task automatic run_word(input logic [15:0] d, input logic c, input logic [1:0] k,
                            input bit hold_done, input bit early_ack, input int wait_cyc);
        exp_t e;
        logic ok;
        @(negedge clk2);
        stg2_in   = {d, c};
        key_bits  = {3'($urandom), k};
        stg2_done = 1'b1;
        ok = (c == model_chk(d, k));
        if (!ok && exp_cnt < CNT_MAX) exp_cnt++;
        e.dec = d; e.ok = ok; e.cnt = exp_cnt;
        exp_q.push_back(e);
        @(posedge clk2);
        @(negedge clk2);
        key_bits = 5'($urandom);
        stg2_in  = 17'($urandom);
        if (!hold_done) stg2_done = 1'b0;
        if (early_ack) ack = 1'b1;
        @(posedge clk2); #1;
        check_val("latency_done", done, 1);
        @(negedge clk2);
        ack = 1'b0;
        repeat (wait_cyc) @(posedge clk2);
        #1 check_val("done_held", done, 1);
        @(negedge clk2);
        ack = 1'b1;
        @(posedge clk2); #1;
        check_val("ack_done", done, 0);
        check_val("ack_ok_err", {chk_ok, chk_err}, 0);
        check_val("dec_kept", dec_out, d);
        check_val("rearm_busy", busy, 1);
        @(negedge clk2);
        ack = 1'b0;
        if (hold_done) begin
            repeat (3) @(posedge clk2);
            #1 check_val("rearm_hold", {busy, done}, 2'b10);
            @(negedge clk2);
            stg2_done = 1'b0;
        end
        @(posedge clk2); #1;
        check_val("idle_busy", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected end before %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        check_val("rst_outputs", {dec_out, chk_ok, chk_err, done, busy}, 0);
`ifdef STAGE2_DEC_ERRCNT_EN
        check_val("rst_err_cnt", err_cnt, 0);
`endif
        @(negedge clk2);
        rst_n = 1'b1;

        run_word(16'h0001, 1'b0, 2'b00, 1'b0, 1'b0, 0);
        run_word(16'hFFFF, 1'b1, 2'b10, 1'b1, 1'b0, 1);
        run_word(16'h0000, 1'b1, 2'b01, 1'b0, 1'b1, 0);
        run_word(16'h1234, 1'b1, 2'b10, 1'b0, 1'b0, 0);
        run_word(16'h8000, 1'b0, 2'b11, 1'b0, 1'b0, 2);
        run_word(16'h0003, 1'b0, 2'b00, 1'b1, 1'b1, 0);

        // Reset while the word sits in CHECK: nothing of it may appear.
        @(negedge clk2);
        stg2_in   = 17'h0ABCD;
        key_bits  = 5'b00001;
        stg2_done = 1'b1;
        @(posedge clk2); #1;
        check_val("capture_busy", busy, 1);
        @(negedge clk2);
        rst_n     = 1'b0;
        stg2_done = 1'b0;
        exp_cnt   = 0;
        #1 check_val("midrst_outputs", {dec_out, chk_ok, chk_err, done, busy}, 0);
`ifdef STAGE2_DEC_ERRCNT_EN
        check_val("midrst_err_cnt", err_cnt, 0);
`endif
        repeat (2) @(negedge clk2);
        rst_n = 1'b1;
        repeat (3) @(posedge clk2);
        #1 check_val("post_rst_quiet", {done, busy}, 0);

        run_word(16'h00F0, 1'b1, 2'b01, 1'b0, 1'b0, 0);

        for (int n = 0; n < 40; n++) begin
            logic [15:0] d;
            d = ($urandom_range(0, 3) == 0) ? 16'hFFFF :
                ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
            run_word(d, 1'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
                     $urandom_range(0, 3));
        end

        repeat (3) @(posedge clk2);
        #1 check_val("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
